// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one multiplier bit per clock, signed/unsigned
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] mcand, mplier;
    logic neg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0] cnt;
    logic last;
    assign last = cnt == CW'(WIDTH - 1);
    assign busy = state != IDLE;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // next state: accept start only when idle, WIDTH run cycles, one finish cycle
    always_comb begin
        state_nx = state;
        if (state == IDLE && start) state_nx = RUN;
        else if (state == RUN && last) state_nx = FINISH;
        else if (state == FINISH) state_nx = IDLE;
    end
    // datapath: capture magnitudes, accumulate partial products, apply sign at finish
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            out    <= '0;
            done   <= 1'b0;
        end else begin
            done <= state == FINISH;
            if (state == IDLE && start) begin
                mcand  <= is_signed && in1[WIDTH-1] ? -in1 : in1;
                mplier <= is_signed && in2[WIDTH-1] ? -in2 : in2;
                neg    <= is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                acc    <= '0;
                cnt    <= '0;
            end
            if (state == RUN) begin
                if (mplier[cnt]) acc <= acc + ({{WIDTH{1'b0}}, mcand} << cnt);
                cnt <= cnt + 1'b1;
            end
            if (state == FINISH) out <= neg ? -acc : acc;
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: randomized and directed checks of seq_multiplier against an arithmetic model
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st32 = 1'b0, s32 = 1'b0, st8 = 1'b0, s8 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic busy32, done32, busy8, done8;
    logic [63:0] out32;
    logic [15:0] out8;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(st32), .is_signed(s32), .in1(a32), .in2(b32),
        .busy(busy32), .done(done32), .out(out32)
    );
    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .is_signed(s8), .in1(a8), .in2(b8),
        .busy(busy8), .done(done8), .out(out8)
    );

    function automatic logic [63:0] model(input bit w8, input logic [31:0] a, input logic [31:0] b, input bit s);
        longint x, y, p;
        if (w8) begin
            if (s) begin x = $signed(a[7:0]); y = $signed(b[7:0]); end
            else begin x = a[7:0]; y = b[7:0]; end
        end else begin
            if (s) begin x = $signed(a); y = $signed(b); end
            else begin x = {32'b0, a}; y = {32'b0, b}; end
        end
        p = x * y;
        return w8 ? {48'b0, p[15:0]} : p;
    endfunction

    task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b, input bit s,
                          output logic [63:0] res, output int lat, output int nb, output int nd);
        int w;
        w = w8 ? 8 : 32;
        @(negedge clk);
        if (w8) begin st8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; s8 = s; end
        else begin st32 = 1'b1; a32 = a; b32 = b; s32 = s; end
        @(negedge clk);
        st8 = 1'b0; st32 = 1'b0;
        a32 = $urandom; b32 = $urandom; s32 = 1'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
        res = '0; lat = -1; nb = 0; nd = 0;
        for (int c = 0; c < w + 6; c++) begin
            if (w8 ? busy8 : busy32) nb++;
            if (w8 ? done8 : done32) begin
                nd++;
                if (lat < 0) begin lat = c; res = w8 ? {48'b0, out8} : out32; end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; st32 = 1'b1; st8 = 1'b1; a32 = 32'd5; b32 = 32'd7; a8 = 8'd5; b8 = 8'd7;
        repeat (3) @(negedge clk);
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy32 got %b want 0", busy32); end
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_done32 got %b want 0", done32); end
        checks++; if (out32 !== 64'd0) begin errors++; $display("FAIL reset_out32 got %h want 0", out32); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8 got %b want 0", done8); end
        checks++; if (out8 !== 16'd0) begin errors++; $display("FAIL reset_out8 got %h want 0", out8); end
        st32 = 1'b0; st8 = 1'b0; rst = 1'b0;
    endtask

    task automatic test_directed32;
        logic [31:0] ta [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'hFFFFFFFD};
        logic [31:0] tb [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h80000000, 32'd5};
        bit ts [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [63:0] te [5] = '{64'hFFFFFFFE00000001, 64'hFFFFFFFFFFFFFFF1, 64'h4000000000000000,
                                64'h4000000000000000, 64'h00000004FFFFFFF1};
        logic [63:0] r;
        int lat, nb, nd;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, ta[i], tb[i], ts[i], r, lat, nb, nd);
            checks++; if (r !== te[i]) begin errors++; $display("FAIL dir32_out[%0d] got %h want %h", i, r, te[i]); end
            checks++; if (lat !== 33) begin errors++; $display("FAIL dir32_latency[%0d] got %0d want 33", i, lat); end
            checks++; if (nb !== 33) begin errors++; $display("FAIL dir32_busy_cycles[%0d] got %0d want 33", i, nb); end
            checks++; if (nd !== 1) begin errors++; $display("FAIL dir32_done_count[%0d] got %0d want 1", i, nd); end
        end
    endtask

    task automatic test_width8;
        logic [31:0] ta [2] = '{32'h80, 32'h00};
        logic [31:0] tb [2] = '{32'h7F, 32'hFF};
        logic [63:0] te [2] = '{64'hC080, 64'h0000};
        logic [63:0] r;
        int lat, nb, nd;
        for (int i = 0; i < 2; i++) begin
            run_op(1'b1, ta[i], tb[i], 1'b1, r, lat, nb, nd);
            checks++; if (r !== te[i]) begin errors++; $display("FAIL w8_out[%0d] got %h want %h", i, r, te[i]); end
            checks++; if (lat !== 9) begin errors++; $display("FAIL w8_latency[%0d] got %0d want 9", i, lat); end
            checks++; if (nb !== 9) begin errors++; $display("FAIL w8_busy_cycles[%0d] got %0d want 9", i, nb); end
            checks++; if (nd !== 1) begin errors++; $display("FAIL w8_done_count[%0d] got %0d want 1", i, nd); end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic [63:0] r, e;
        bit w8, s;
        int lat, nb, nd;
        for (int i = 0; i < 24; i++) begin
            w8 = i[0];
            s = 1'($urandom);
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) == 0) a = w8 ? 32'h80 : 32'h80000000;
            if ($urandom_range(0, 3) == 0) b = w8 ? 32'hFF : 32'hFFFFFFFF;
            e = model(w8, a, b, s);
            run_op(w8, a, b, s, r, lat, nb, nd);
            checks++; if (r !== e) begin errors++; $display("FAIL rand_out[%0d] w8=%0d s=%0d a=%h b=%h got %h want %h", i, w8, s, a, b, r, e); end
            checks++; if (lat !== (w8 ? 9 : 33)) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, lat, w8 ? 9 : 33); end
            checks++; if (nd !== 1) begin errors++; $display("FAIL rand_done_count[%0d] got %0d want 1", i, nd); end
        end
    endtask

    task automatic test_busy_ignore;
        int nd, first;
        logic [63:0] r;
        @(negedge clk); s32 = 1'b0; a32 = 32'd7; b32 = 32'd6; st32 = 1'b1;
        @(negedge clk); st32 = 1'b0;
        nd = 0; first = -1; r = '0;
        for (int c = 0; c < 60; c++) begin
            if (done32) begin nd++; if (first < 0) begin first = c; r = out32; end end
            if (c == 10) begin st32 = 1'b1; a32 = 32'd2; b32 = 32'd2; end
            else st32 = 1'b0;
            @(negedge clk);
        end
        checks++; if (nd !== 1) begin errors++; $display("FAIL busy_ignore_done_count got %0d want 1", nd); end
        checks++; if (first !== 33) begin errors++; $display("FAIL busy_ignore_latency got %0d want 33", first); end
        checks++; if (r !== 64'd42) begin errors++; $display("FAIL busy_ignore_out got %0d want 42", r); end
    endtask

    task automatic test_reset_mid;
        int nd, lat, nb;
        logic [63:0] r;
        @(negedge clk); s32 = 1'b0; a32 = 32'd100; b32 = 32'd100; st32 = 1'b1;
        @(negedge clk); st32 = 1'b0;
        for (int c = 0; c < 15; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy32); end
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", done32); end
        checks++; if (out32 !== 64'd0) begin errors++; $display("FAIL rst_mid_out got %h want 0", out32); end
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (done32) nd++;
            @(negedge clk);
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL rst_mid_stray_done got %0d want 0", nd); end
        run_op(1'b0, 32'd9, 32'd9, 1'b0, r, lat, nb, nd);
        checks++; if (r !== 64'd81) begin errors++; $display("FAIL rst_mid_recover_out got %0d want 81", r); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL rst_mid_recover_latency got %0d want 33", lat); end
    endtask

    task automatic test_back_to_back;
        int c;
        logic [31:0] la [0:127];
        logic [31:0] lb [0:127];
        bit ls [0:127];
        bit hit;
        @(negedge clk); s32 = 1'b0; a32 = 32'd7; b32 = 32'd6; st32 = 1'b1;
        @(negedge clk); st32 = 1'b0; c = 0;
        while (!done32 && c < 50) begin @(negedge clk); c++; end
        checks++; if (c !== 33) begin errors++; $display("FAIL b2b_first_latency got %0d want 33", c); end
        checks++; if (out32 !== 64'd42) begin errors++; $display("FAIL b2b_first_out got %0d want 42", out32); end
        st32 = 1'b1; a32 = 32'd3; b32 = 32'd4; s32 = 1'b0;
        @(negedge clk); st32 = 1'b0; c = 1;
        while (!done32 && c < 60) begin @(negedge clk); c++; end
        checks++; if (c !== 34) begin errors++; $display("FAIL b2b_second_spacing got %0d want 34", c); end
        checks++; if (out32 !== 64'd12) begin errors++; $display("FAIL b2b_second_out got %0d want 12", out32); end
        repeat (3) @(negedge clk);
        la[0] = $urandom; lb[0] = $urandom; ls[0] = 1'($urandom);
        a32 = la[0]; b32 = lb[0]; s32 = ls[0]; st32 = 1'b1;
        for (int k = 0; k <= 105; k++) begin
            @(negedge clk);
            hit = (k == 33) || (k == 67) || (k == 101);
            checks++; if (done32 !== hit) begin errors++; $display("FAIL held_done[%0d] got %b want %b", k, done32, hit); end
            if (hit) begin
                checks++;
                if (out32 !== model(1'b0, la[k-33], lb[k-33], ls[k-33])) begin
                    errors++; $display("FAIL held_out[%0d] got %h want %h", k, out32, model(1'b0, la[k-33], lb[k-33], ls[k-33]));
                end
            end
            la[k+1] = $urandom; lb[k+1] = $urandom; ls[k+1] = 1'($urandom);
            a32 = la[k+1]; b32 = lb[k+1]; s32 = ls[k+1];
            st32 = k < 68;
        end
        st32 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed32();
        test_width8();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
